// File: rtl/rtl_handshake_source.sv
// rtl_handshake_source
// Ready/valid transmitter: operand pairs are queued in a small FIFO. The head
// entry is offered at the same time on the main channel and on one of three
// lane channels, chosen by in2 mod 3. The entry leaves the FIFO only after both
// sides have completed their handshakes. Every valid, out and push_ready is
// derived from registered state only, so no ready feeds back into a valid.
module rtl_handshake_source #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         in1,
  input  logic [WIDTH-1:0]         in2,
  output logic                     handshake_valid,
  input  logic                     handshake_ready,
  output logic                     out,
  output logic                     handshake_arr_0_valid,
  input  logic                     handshake_arr_0_ready,
  output logic                     handshake_arr_1_valid,
  input  logic                     handshake_arr_1_ready,
  output logic                     handshake_arr_2_valid,
  input  logic                     handshake_arr_2_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Operand storage, indexed by the FIFO pointers
  logic [WIDTH-1:0] mem_in1 [DEPTH];
  logic [WIDTH-1:0] mem_in2 [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          main_done;
  logic          lane_done;

  logic             not_empty;
  logic             full;
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] h2;
  logic [1:0]       lane;
  logic             lane_valid;
  logic             lane_ready;
  logic             push_fire;
  logic             main_fire;
  logic             lane_fire;
  logic             retire;

  assign not_empty  = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign push_ready = !full;
  assign push_fire  = push_valid & push_ready;

  assign h1   = mem_in1[rd_ptr];
  assign h2   = mem_in2[rd_ptr];
  assign lane = 2'(h2 % WIDTH'(3));

  // The monitor requires out === (|in1) && (&in1) for the head entry
  assign out             = not_empty & (|h1) & (&h1);
  assign handshake_valid = not_empty & !main_done;
  assign lane_valid      = not_empty & !lane_done;

  assign handshake_arr_0_valid = lane_valid & (lane == 2'd0);
  assign handshake_arr_1_valid = lane_valid & (lane == 2'd1);
  assign handshake_arr_2_valid = lane_valid & (lane == 2'd2);

  // Pick the ready of the lane that the head entry is using
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // lane_ready unassigned, which would infer a latch.
    lane_ready = 1'b0;
    case (lane)
      2'd0:    lane_ready = handshake_arr_0_ready;
      2'd1:    lane_ready = handshake_arr_1_ready;
      2'd2:    lane_ready = handshake_arr_2_ready;
      default: lane_ready = 1'b0;
    endcase
  end

  assign main_fire = handshake_valid & handshake_ready;
  assign lane_fire = lane_valid & lane_ready;
  // Both fires together retire at once; otherwise the later fire retires
  assign retire    = not_empty & (main_done | main_fire) & (lane_done | lane_fire);

  // Operand write on push
  always_ff @(posedge CLK) begin
    // NOTE: the storage array has no reset; occupancy is tracked by count, so
    // a stale word is never presented, and leaving it unreset keeps it plain RAM.
    if (push_fire) begin
      mem_in1[wr_ptr] <= in1;
      mem_in2[wr_ptr] <= in2;
    end
  end

  // Pointers, occupancy and fork flags
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      main_done <= 1'b0;
      lane_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, regardless of statement order.
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (retire)    rd_ptr <= rd_ptr + AW'(1);

      case ({push_fire, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (retire) begin
        main_done <= 1'b0;
        lane_done <= 1'b0;
      end else begin
        if (main_fire) main_done <= 1'b1;
        if (lane_fire) lane_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtl_handshake_source.sv
// Testbench for rtl_handshake_source: directed scenarios plus a randomized
// stream, all compared every cycle against a queue-based reference model.
module tb_rtl_handshake_source;

  localparam int DEPTH = 2;
  localparam int WIDTH = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 6 + CW;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             handshake_valid;
  logic             handshake_ready;
  logic             out;
  logic [2:0]       lane_valid;
  logic [2:0]       lane_ready;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending entries in push order and which sides of the
  // head entry have already been served.
  entry_t q[$];
  bit     main_served;
  bit     lane_served;
  bit     last_push_fired;

  rtl_handshake_source #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK                   (CLK),
    .ASYNCRESETN           (ASYNCRESETN),
    .push_valid            (push_valid),
    .push_ready            (push_ready),
    .in1                   (in1),
    .in2                   (in2),
    .handshake_valid       (handshake_valid),
    .handshake_ready       (handshake_ready),
    .out                   (out),
    .handshake_arr_0_valid (lane_valid[0]),
    .handshake_arr_0_ready (lane_ready[0]),
    .handshake_arr_1_valid (lane_valid[1]),
    .handshake_arr_1_ready (lane_ready[1]),
    .handshake_arr_2_valid (lane_valid[2]),
    .handshake_arr_2_ready (lane_ready[2]),
    .count                 (count)
  );

  always #5 CLK = ~CLK;

  // Observed outputs packed as {push_ready, hv, out, lane2..0, count}
  function automatic logic [VW-1:0] obs_vec();
    return {push_ready, handshake_valid, out, lane_valid, count};
  endfunction

  function automatic int head_lane();
    return int'(q[0].b) % 3;
  endfunction

  // Expected outputs from the model state
  function automatic logic [VW-1:0] exp_vec();
    logic       pr;
    logic       hv;
    logic       o;
    logic [2:0] lv;
    pr = (q.size() < DEPTH);
    hv = 1'b0;
    o  = 1'b0;
    lv = 3'b000;
    if (q.size() != 0) begin
      hv = !main_served;
      o  = (q[0].a == {WIDTH{1'b1}});
      if (!lane_served) lv[head_lane()] = 1'b1;
    end
    return {pr, hv, o, lv, CW'(q.size())};
  endfunction

  function automatic logic [VW-1:0] reset_vec();
    return {1'b1, 1'b0, 1'b0, 3'b000, {CW{1'b0}}};
  endfunction

  // Apply the current inputs to the model across one rising edge
  task automatic advance();
    bit     pf;
    bit     mf;
    bit     lf;
    bit     ret;
    entry_t e;
    pf = push_valid && (q.size() < DEPTH);
    mf = 1'b0;
    lf = 1'b0;
    if (q.size() != 0) begin
      mf = !main_served && handshake_ready;
      lf = !lane_served && lane_ready[head_lane()];
    end
    ret = (q.size() != 0) && (main_served || mf) && (lane_served || lf);
    e.a = in1;
    e.b = in2;
    @(posedge CLK);
    #1;
    if (ret) begin
      void'(q.pop_front());
      main_served = 1'b0;
      lane_served = 1'b0;
    end else begin
      if (mf) main_served = 1'b1;
      if (lf) lane_served = 1'b1;
    end
    if (pf) q.push_back(e);
    last_push_fired = pf;
  endtask

  task automatic model_clear();
    q.delete();
    main_served = 1'b0;
    lane_served = 1'b0;
  endtask

  task automatic test_reset();
    ASYNCRESETN     = 1'b0;
    push_valid      = 1'b0;
    in1             = '0;
    in2             = '0;
    handshake_ready = 1'b1;
    lane_ready      = 3'b111;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #3;
      n_checks++;
      if (obs_vec() !== reset_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs_vec(), reset_vec());
      end
      advance();
    end
  endtask

  task automatic test_single();
    handshake_ready = 1'b1;
    lane_ready      = 3'b111;
    push_valid      = 1'b1;
    in1             = 5'h1F;
    in2             = 5'd4;
    #3;
    advance();
    push_valid = 1'b0;
    #3;
    n_checks++;
    if ({handshake_valid, out, lane_valid, count} !== {1'b1, 1'b1, 3'b010, CW'(1)}) begin
      n_fail++;
      $display("FAIL single_head: got hv=%b out=%b lanes=%b count=%0d expected hv=1 out=1 lanes=010 count=1",
               handshake_valid, out, lane_valid, count);
    end
    advance();
    #3;
    n_checks++;
    if (obs_vec() !== reset_vec()) begin
      n_fail++;
      $display("FAIL single_retire: got %b expected %b", obs_vec(), reset_vec());
    end
    advance();
  endtask

  task automatic test_main_first();
    handshake_ready = 1'b1;
    lane_ready      = 3'b000;
    push_valid      = 1'b1;
    in1             = 5'h0F;
    in2             = 5'd6;
    #3;
    advance();
    push_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lane_ready = 3'b001;
      #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL main_first cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i >= 1) begin
        n_checks++;
        if ({handshake_valid, out, lane_valid} !== 5'b00001) begin
          n_fail++;
          $display("FAIL main_first_wait cyc %0d: got hv/out/lanes %b expected 00001",
                   i, {handshake_valid, out, lane_valid});
        end
      end
      advance();
    end
    #3;
    n_checks++;
    if (count !== CW'(0)) begin
      n_fail++;
      $display("FAIL main_first_retire: got count %0d expected 0", count);
    end
    lane_ready = 3'b000;
    advance();
  endtask

  task automatic test_full();
    entry_t src[3];
    int     idx = 0;
    int     cyc = 0;
    src[0].a = 5'h1F; src[0].b = 5'd0;
    src[1].a = 5'h03; src[1].b = 5'd1;
    src[2].a = 5'h1F; src[2].b = 5'd2;
    handshake_ready = 1'b0;
    lane_ready      = 3'b000;
    while ((idx < 3 || q.size() != 0) && cyc < 40) begin
      if (cyc == 4) begin
        handshake_ready = 1'b1;
        lane_ready      = 3'b111;
      end
      push_valid = (idx < 3);
      in1 = (idx < 3) ? src[idx].a : '0;
      in2 = (idx < 3) ? src[idx].b : '0;
      #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
      end
      if (cyc == 2 || cyc == 4) begin
        n_checks++;
        if ({push_ready, count} !== {1'b0, CW'(2)}) begin
          n_fail++;
          $display("FAIL full_stall cyc %0d: got push_ready=%b count=%0d expected 0 and 2",
                   cyc, push_ready, count);
        end
      end
      advance();
      if (last_push_fired) idx++;
      cyc++;
    end
    push_valid = 1'b0;
    n_checks++;
    if (cyc >= 40) begin
      n_fail++;
      $display("FAIL full_timeout: got %0d pushes expected 3 drained", idx);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int cyc    = 0;
    while ((pushed < 20 || q.size() != 0) && cyc < 600) begin
      push_valid      = (pushed < 20) && ($urandom_range(0, 3) != 0);
      in1             = ($urandom_range(0, 2) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
      in2             = WIDTH'($urandom);
      handshake_ready = 1'($urandom_range(0, 1));
      lane_ready      = 3'($urandom);
      #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
      end
      advance();
      if (last_push_fired) pushed++;
      cyc++;
    end
    push_valid = 1'b0;
    n_checks++;
    if (cyc >= 600) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d pushed, %0d pending expected 20 drained", pushed, q.size());
    end
  endtask

  task automatic test_reset_mid();
    handshake_ready = 1'b0;
    lane_ready      = 3'b000;
    push_valid      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in1 = 5'h1F;
      in2 = WIDTH'(i + 1);
      #3;
      advance();
    end
    push_valid = 1'b0;
    #1;
    n_checks++;
    if (count !== CW'(2)) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got count %0d expected 2", count);
    end
    #1;
    ASYNCRESETN = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (obs_vec() !== reset_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", obs_vec(), reset_vec());
    end
    @(posedge CLK);
    #1;
    ASYNCRESETN     = 1'b1;
    handshake_ready = 1'b1;
    lane_ready      = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #3;
      n_checks++;
      if (obs_vec() !== reset_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_stale cyc %0d: got %b expected %b", i, obs_vec(), reset_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_main_first();
    test_full();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtl_handshake_source.md
# rtl_handshake_source

Ready/valid transmitter that drives the `handshake` and `handshake_arr_*` channels of the RTL_unq1 datapath under test. It is the producing end of the protocol that `RTLMonitor_unq1` checks. Operand pairs `in1`/`in2` are queued in a small FIFO. Each head entry is forked onto the main channel and onto one of three lane channels. The entry retires only when both sides have completed their handshakes. The main-channel `out` bit is generated so that the monitor property `handshake_valid -> out === (|in1) && (&in1)` holds for the head entry.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries; power of two, 2..8.
- `WIDTH`, default 5: operand width.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `ASYNCRESETN` in 1: reset, asynchronous assertion, active-low.
- `push_valid` in 1: producer offers `in1`/`in2`.
- `push_ready` out 1: FIFO can accept; equals `!full`.
- `in1` in WIDTH: operand 1.
- `in2` in WIDTH: operand 2.
- `handshake_valid` out 1: main channel valid.
- `handshake_ready` in 1: main channel ready from the consumer.
- `out` out 1: main channel payload.
- `handshake_arr_k_valid` out 1, for k = 0..2: lane k valid.
- `handshake_arr_k_ready` in 1, for k = 0..2: lane k ready.
- `count` out clog2(DEPTH)+1: current occupancy.

## Operation
- Push:
  - A push fires when `push_valid && push_ready`.
  - It writes {`in1`, `in2`} at `wr_ptr`, then increments `wr_ptr` modulo DEPTH.
  - There is no bypass, so a push into an empty FIFO becomes visible the next cycle.
- Head: `h1`, `h2` denote the entry at `rd_ptr`, valid when `count != 0`.
- Main payload: `out = (|h1) & (&h1)` when `count != 0`, else 0.
- Lane select: `lane = h2 mod 3`; values 0..31 map to lane 0, 1 or 2.
- Fork state: two registered flags, `main_done` and `lane_done`, both cleared at reset and on each retire.
  - `handshake_valid = (count != 0) & !main_done`.
  - `handshake_arr_k_valid = (count != 0) & !lane_done & (lane == k)`. Non-selected lanes are always 0.
  - A main fire is `handshake_valid & handshake_ready`. It sets `main_done`.
  - A lane fire is the selected lane's valid & ready. It sets `lane_done`.
- Retire: occurs in the cycle where `(main_done | main fire) & (lane_done | lane fire)`.
  - On retire, `rd_ptr` increments, both flags clear and `count` decrements.
  - Both fires in the same cycle retire in that cycle.
- Simultaneous push and retire: `count` is unchanged and both pointers advance.
- Full: `push_ready` is 0 even if a retire happens the same cycle; there is no same-cycle refill.
- Valid stability: once asserted, a valid stays high with stable payload and stable lane until its own fire. Ready is never required before valid.
- Reset mid-operation: all entries are discarded, pointers and `count` go to 0, and flags clear. Any in-flight handshake is abandoned without a fire.

## Timing
- Reset values: `handshake_valid` = 0, all `handshake_arr_k_valid` = 0, `out` = 0, `count` = 0, `push_ready` = 1.
- Latency from push to `handshake_valid`: 1 cycle when the FIFO is empty.
- Head entry with both readies high: retires in 1 cycle, giving a throughput of 1 entry/cycle once primed.
- A side that fires first drops its valid on the next cycle and waits for the other side; the entry retires when the other side fires.
- `push_ready`, all valids and `out` are functions of registered state only. There is no combinational path from any ready to any valid.
- `count` is registered and reflects fires up to and including the previous edge.
- Pointer wrap: at `DEPTH-1` the pointer returns to 0. Full when `count == DEPTH`, empty when `count == 0`.

## Test plan
- Reset release with all readies high and no push -> all valids 0, `out` 0, `count` 0, `push_ready` 1 held for 10 cycles.
- Push `in1`=5'h1F, `in2`=5'd4 -> next cycle `handshake_valid`=1 with `out`=1 and `handshake_arr_1_valid`=1 (4 mod 3 = 1), other lanes 0; with all readies high the entry retires in that cycle and `count` returns to 0.
- Push `in1`=5'h0F, `in2`=5'd6 with `handshake_ready`=1 and lane readies 0 for 3 cycles -> `out`=0, main fires in cycle 1 then main valid stays 0; `handshake_arr_0_valid` holds for 3 cycles; retire on the cycle lane 0 ready rises.
- With DEPTH=2, push 3 back-to-back with readies 0 -> `push_ready` goes 0 after 2 accepts, `count`=2, the third push is stalled; raising all readies retires 1/cycle and the third push is accepted once `count`=1.
- Stream 20 random pairs with random readies -> the order of `out` and lane sequence matches the push order; the monitor assertion never fails; pointers wrap without loss.
- Drop `ASYNCRESETN` mid-stream with `count`=2 -> outputs return to reset values immediately without waiting for `CLK`; after release, no stale entry appears.
